// File: rtl/duty_ramp.sv
// Triangle-with-plateaus duty generator: RISE -> HOLD_HI -> FALL -> HOLD_LO, one step per prescaled tick.
// Outputs are registered (one edge after the tick); en=0 freezes state, restart forces the origin.
module duty_ramp #(
  parameter int unsigned PRESCALE   = 1024,
  parameter int unsigned STEP       = 64,
  parameter int unsigned HOLD_TICKS = 256
) (
  input  logic        clk,
  input  logic        CLRN,
  input  logic        en,
  input  logic        restart,
  output logic [15:0] DUTY,
  output logic [1:0]  phase,
  output logic        peak,
  output logic        trough
);

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } phase_t;

  localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [16:0]   STEP_W     = 17'(STEP);
  localparam logic [15:0]   HOLD_LAST  = 16'(HOLD_TICKS - 1);

  phase_t        state, state_nx;
  logic [15:0]   duty_nx;
  logic [15:0]   hold, hold_nx;
  logic [PW-1:0] presc, presc_nx;
  logic          peak_nx, trough_nx;
  logic          tick;
  logic [16:0]   sum;

  assign tick  = en && (presc == PRESC_LAST);
  // 17-bit sum so the carry flags saturation instead of wrapping
  assign sum   = {1'b0, DUTY} + STEP_W;
  assign phase = state;

  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      state  <= RISE;
      DUTY   <= '0;
      hold   <= '0;
      presc  <= '0;
      peak   <= 1'b0;
      trough <= 1'b0;
    end else begin
      state  <= state_nx;
      DUTY   <= duty_nx;
      hold   <= hold_nx;
      presc  <= presc_nx;
      peak   <= peak_nx;
      trough <= trough_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    duty_nx   = DUTY;
    hold_nx   = hold;
    presc_nx  = presc;
    peak_nx   = 1'b0;
    trough_nx = 1'b0;
    if (restart) begin
      state_nx = RISE;
      duty_nx  = '0;
      hold_nx  = '0;
      presc_nx = '0;
    end else if (en) begin
      presc_nx = tick ? '0 : presc + PW'(1);
      if (tick) begin
        case (state)
          RISE: begin
            if (sum[16]) begin
              duty_nx  = 16'hFFFF;
              state_nx = HOLD_HI;
              hold_nx  = '0;
              peak_nx  = 1'b1;
            end else begin
              duty_nx = sum[15:0];
            end
          end
          FALL: begin
            if ({1'b0, DUTY} < STEP_W) begin
              duty_nx   = '0;
              state_nx  = HOLD_LO;
              hold_nx   = '0;
              trough_nx = 1'b1;
            end else begin
              duty_nx = DUTY - STEP_W[15:0];
            end
          end
          default: begin
            // both plateaus share the counter; the last tick leaves and clears it
            if (hold == HOLD_LAST) begin
              hold_nx  = '0;
              state_nx = (state == HOLD_HI) ? FALL : RISE;
            end else begin
              hold_nx = hold + 16'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// Bench for duty_ramp: directed ramp/pause/restart/reset steps plus random en/restart,
// all checked every cycle against a tick-count based reference.
module tb_duty_ramp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clrn_a, en_a, restart_a, peak_a, trough_a;
  logic [15:0] duty_a;
  logic [1:0]  phase_a;
  logic        clrn_s, en_s, restart_s, peak_s, trough_s;
  logic [15:0] duty_s;
  logic [1:0]  phase_s;

  duty_ramp #(.PRESCALE(4), .STEP(16'h4000), .HOLD_TICKS(2)) u_a (
    .clk(clk), .CLRN(clrn_a), .en(en_a), .restart(restart_a),
    .DUTY(duty_a), .phase(phase_a), .peak(peak_a), .trough(trough_a));

  duty_ramp #(.PRESCALE(1), .STEP(16'hFFFF), .HOLD_TICKS(1)) u_s (
    .clk(clk), .CLRN(clrn_s), .en(en_s), .restart(restart_s),
    .DUTY(duty_s), .phase(phase_s), .peak(peak_s), .trough(trough_s));

  int unsigned pre [2] = '{4, 1};
  int unsigned stp [2] = '{16384, 65535};
  int unsigned hld [2] = '{2, 1};
  int unsigned ecnt[2] = '{0, 0};   // enabled edges since reset/restart
  bit          ltick[2] = '{0, 0};  // previous edge was a tick
  int passed = 0, total = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected outputs from the number of ticks k since the ramp origin.
  // Rise and fall each take STEP-count ticks n = floor(65535/STEP)+1 (the last one saturates).
  function automatic void ref_out(input int i, output logic [15:0] d, output logic [1:0] ph,
                                  output logic pk, output logic tr);
    int unsigned k, n, h, p, s, j;
    s = stp[i]; h = hld[i]; n = 65535 / s + 1; k = ecnt[i] / pre[i];
    d = 16'h0; ph = 2'd0; pk = 1'b0; tr = 1'b0;
    if (k > 0) begin
      p = (k - 1) % (2 * n + 2 * h);
      if (p < n) begin
        j = p + 1;
        if (j < n) d = 16'(j * s);
        else begin d = 16'hFFFF; ph = 2'd1; pk = ltick[i]; end
      end else if (p < n + h) begin
        d = 16'hFFFF; ph = (p - n + 1 < h) ? 2'd1 : 2'd2;
      end else if (p < 2 * n + h) begin
        j = p - n - h + 1;
        if (j < n) begin d = 16'(65535 - j * s); ph = 2'd2; end
        else begin d = 16'h0; ph = 2'd3; tr = ltick[i]; end
      end else begin
        d = 16'h0; ph = (p - 2 * n - h + 1 < h) ? 2'd3 : 2'd0;
      end
    end
  endfunction

  task automatic model_edge(input int i, input logic c, input logic e, input logic r);
    if (!c || r) begin
      ecnt[i] = 0; ltick[i] = 1'b0;
    end else if (e) begin
      ecnt[i]++; ltick[i] = (ecnt[i] % pre[i] == 0);
    end else begin
      ltick[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [15:0] d; logic [1:0] ph; logic pk, tr;
    ref_out(0, d, ph, pk, tr);
    chk("a_duty", 32'(duty_a), 32'(d));
    chk("a_phase", 32'(phase_a), 32'(ph));
    chk("a_peak", 32'(peak_a), 32'(pk));
    chk("a_trough", 32'(trough_a), 32'(tr));
    ref_out(1, d, ph, pk, tr);
    chk("s_duty", 32'(duty_s), 32'(d));
    chk("s_phase", 32'(phase_s), 32'(ph));
    chk("s_peak", 32'(peak_s), 32'(pk));
    chk("s_trough", 32'(trough_s), 32'(tr));
  endtask

  // One clock edge, model update, check 1 time unit later
  task automatic step_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge(0, clrn_a, en_a, restart_a);
      model_edge(1, clrn_s, en_s, restart_s);
      #1 check_all();
    end
  endtask

  initial begin
    clrn_a = 1'b0; en_a = 1'b0; restart_a = 1'b0;
    clrn_s = 1'b0; en_s = 1'b0; restart_s = 1'b0;
    #1 check_all();
    chk("reset_duty", 32'(duty_a), 32'h0);
    step_cyc(2);

    // ramp up, hold, fall, hold
    clrn_a = 1'b1; en_a = 1'b1;
    step_cyc(4);  chk("e4_duty", 32'(duty_a), 32'h4000);
    step_cyc(4);  chk("e8_duty", 32'(duty_a), 32'h8000);
    step_cyc(8);  chk("e16_duty", 32'(duty_a), 32'hFFFF);
    chk("e16_peak", 32'(peak_a), 32'h1);
    chk("e16_phase", 32'(phase_a), 32'h1);
    step_cyc(1);  chk("e17_peak", 32'(peak_a), 32'h0);
    step_cyc(7);  chk("e24_phase", 32'(phase_a), 32'h2);
    step_cyc(4);  chk("e28_duty", 32'(duty_a), 32'hBFFF);
    step_cyc(12); chk("e40_trough", 32'(trough_a), 32'h1);
    chk("e40_phase", 32'(phase_a), 32'h3);
    step_cyc(8);  chk("e48_phase", 32'(phase_a), 32'h0);

    // pause at 8000, two cycles before the next tick
    step_cyc(10); chk("pause_at", 32'(duty_a), 32'h8000);
    en_a = 1'b0;
    step_cyc(10); chk("pause_frozen", 32'(duty_a), 32'h8000);
    en_a = 1'b1;
    step_cyc(1);  chk("pause_no_early", 32'(duty_a), 32'h8000);
    step_cyc(1);  chk("pause_tick", 32'(duty_a), 32'hC000);

    // restart mid-fall
    step_cyc(16); chk("fall_bfff", 32'(duty_a), 32'hBFFF);
    restart_a = 1'b1;
    step_cyc(1);  chk("rst_duty", 32'(duty_a), 32'h0);
    chk("rst_phase", 32'(phase_a), 32'h0);
    restart_a = 1'b0;
    step_cyc(4);  chk("rst_resume", 32'(duty_a), 32'h4000);

    // asynchronous reset mid HOLD_HI, between edges
    step_cyc(16);
    #2 clrn_a = 1'b0;
    #1 ecnt[0] = 0; ltick[0] = 1'b0;
    chk("areset_duty", 32'(duty_a), 32'h0);
    chk("areset_phase", 32'(phase_a), 32'h0);
    #2 clrn_a = 1'b1;
    step_cyc(16); chk("areset_repeat", 32'(duty_a), 32'hFFFF);
    chk("areset_peak", 32'(peak_a), 32'h1);

    // saturating instance: one-cycle plateaus
    clrn_s = 1'b1; en_s = 1'b1;
    step_cyc(2);  chk("sat_peak", 32'(peak_s), 32'h1);
    step_cyc(2);  chk("sat_zero", 32'(duty_s), 32'h0);
    step_cyc(1);  chk("sat_trough", 32'(trough_s), 32'h1);
    step_cyc(2);  chk("sat_again", 32'(duty_s), 32'hFFFF);

    // random en/restart on both instances
    for (int c = 0; c < 3000; c++) begin
      en_a      = ($urandom_range(0, 9) != 0);
      restart_a = ($urandom_range(0, 79) == 0);
      en_s      = ($urandom_range(0, 4) != 0);
      restart_s = ($urandom_range(0, 39) == 0);
      step_cyc(1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
